// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: funct codes, HI/LO read selects and
// the multiply FSM state type.
package mips_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  localparam logic [1:0] LOHI_NONE = 2'b00;
  localparam logic [1:0] LOHI_HI   = 2'b01;
  localparam logic [1:0] LOHI_LO   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_iter_core.sv
// Iterative shift-add multiplier datapath: accumulator, per-cycle add/shift
// step and iteration counter. Operands are unsigned magnitudes.
// Optional macro MULT_EARLY_OUT_EN: finish early once the remaining
// multiplier bits are all zero.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                latch operands, clear accumulator and counter
//   step                perform one shift-add iteration
//   mcand_in, mplier_in unsigned multiplicand / multiplier
//   product             current 2*WIDTH accumulator contents
//   last_c              this step is the final one
module mult_iter_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   upper_sum;
  logic [PW:0]      acc_wide;

`ifdef MULT_EARLY_OUT_EN
  localparam int unsigned SHW = CNT_W + 1;
  logic [SHW-1:0] remaining;
`endif

  // One iteration: add into the upper half with carry, then shift right by 1
  always_comb begin
    upper_sum = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_wide  = {upper_sum, acc_q[WIDTH-1:0]};
    acc_d     = acc_wide[PW:1];
    mplier_d  = mplier_q >> 1;
    cnt_d     = cnt_q + CNT_W'(1);
    last_c    = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_OUT_EN
    // No more partial products: apply all outstanding shifts at once
    remaining = SHW'(WIDTH) - SHW'(cnt_q);
    if (mplier_q == '0) begin
      acc_d  = acc_q >> remaining;
      last_c = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= mcand_in;
      mplier_q <= mplier_in;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/mult_hilo_unit.sv
// Execute-stage MULT/MULTU unit owning the HI/LO registers and serving
// MFHI/MFLO reads, with a stall while a multiply is in flight.
// Optional macro MULT_EARLY_OUT_EN: early termination in the iterative core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid, hi_en, lo_en      multiply request when all three are high
//   funct                    6'h18 signed MULT, otherwise unsigned
//   alu_lo_hi                01 read HI, 10 read LO
//   rs_val, rt_val           operands
//   kill                     flush; aborts an in-flight multiply
//   busy                     multiply in flight
//   stall                    hold EX this cycle (combinational)
//   mf_result                selected HI/LO or 0 (combinational)
//   hi_out, lo_out           architectural HI/LO registers
module mult_hilo_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             hi_en,
  input  logic             lo_en,
  input  logic [5:0]       funct,
  input  logic [1:0]       alu_lo_hi,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             kill,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] mf_result,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned PW = 2 * WIDTH;

  mult_state_t      state_q, state_d;
  logic             sign_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             req;
  logic             is_signed;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             load, step, write_en;
  logic             core_last;
  logic [PW-1:0]    product, result;

  assign req       = valid & hi_en & lo_en;
  assign is_signed = (funct == FUNCT_MULT);

  // Signed multiply runs on magnitudes; the most-negative value maps onto itself
  always_comb begin
    rs_mag = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  end

  assign result = sign_q ? -product : product;

  mult_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mcand_in  (rs_mag),
    .mplier_in (rt_mag),
    .product   (product),
    .last_c    (core_last)
  );

  // Next-state and control strobes
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !kill) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (core_last) state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        write_en = !kill;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sign and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) sign_q <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      if (write_en) begin
        hi_q <= result[PW-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = busy & (req | (alu_lo_hi == LOHI_HI) | (alu_lo_hi == LOHI_LO));
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  // Reads during a multiply see the old HI/LO; the stall keeps them from retiring
  always_comb begin
    case (alu_lo_hi)
      LOHI_HI: mf_result = hi_q;
      LOHI_LO: mf_result = lo_q;
      default: mf_result = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed self-checking bench for mult_hilo_unit (WIDTH=32).
module tb_mult_hilo_unit;

`ifdef MULT_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        hi_en = 1'b0;
  logic        lo_en = 1'b0;
  logic [5:0]  funct = 6'h00;
  logic [1:0]  alu_lo_hi = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        kill = 1'b0;
  logic        busy, stall;
  logic [31:0] mf_result, hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .hi_en     (hi_en),
    .lo_en     (lo_en),
    .funct     (funct),
    .alu_lo_hi (alu_lo_hi),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .kill      (kill),
    .busy      (busy),
    .stall     (stall),
    .mf_result (mf_result),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request cycle, then wait (bounded) until the unit is idle
  task automatic run_mult(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int n);
    valid = 1'b1; hi_en = 1'b1; lo_en = 1'b1;
    funct = f; rs_val = a; rt_val = b;
    tick();
    valid = 1'b0; hi_en = 1'b0; lo_en = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    alu_lo_hi = 2'b01;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_mf", 64'(mf_result), 64'd0);
    alu_lo_hi = 2'b00;

    // MULTU 7*6
    run_mult(6'h19, 32'd7, 32'd6, n);
    check("multu_7x6_latency", 64'(n), EARLY ? 64'd5 : 64'd33);
    check("multu_7x6_hi", 64'(hi_out), 64'h0);
    check("multu_7x6_lo", 64'(lo_out), 64'h2A);

    // MULT -3*5
    run_mult(6'h18, 32'hFFFF_FFFD, 32'd5, n);
    check("mult_neg_timeout", 64'(n < 100), 64'd1);
    check("mult_neg_hi", 64'(hi_out), 64'hFFFF_FFFF);
    check("mult_neg_lo", 64'(lo_out), 64'hFFFF_FFF1);

    // MULT most-negative squared
    run_mult(6'h18, 32'h8000_0000, 32'h8000_0000, n);
    check("mult_minmin_hi", 64'(hi_out), 64'h4000_0000);
    check("mult_minmin_lo", 64'(lo_out), 64'h0);

    // MULTU max*max
    run_mult(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_max_hi", 64'(hi_out), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo_out), 64'h1);

    // MULTU 9*0: early-out vs full latency, same result
    run_mult(6'h19, 32'd9, 32'd0, n);
    check("multu_9x0_latency", 64'(n), EARLY ? 64'd2 : 64'd33);
    check("multu_9x0_hi", 64'(hi_out), 64'h0);
    check("multu_9x0_lo", 64'(lo_out), 64'h0);

    // Back-to-back: second request held by stall, accepted after the DONE write
    valid = 1'b1; hi_en = 1'b1; lo_en = 1'b1; funct = 6'h19;
    rs_val = 32'd3; rt_val = 32'd4;
    tick();
    rs_val = 32'd5; rt_val = 32'd6;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1) bad++;
      tick();
      n++;
    end
    check("b2b_stall_while_busy", 64'(bad), 64'd0);
    check("b2b_first_lo", 64'(lo_out), 64'd12);
    check("b2b_stall_idle", 64'(stall), 64'd0);
    tick();
    check("b2b_second_accepted", 64'(busy), 64'd1);
    valid = 1'b0; hi_en = 1'b0; lo_en = 1'b0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("b2b_second_lo", 64'(lo_out), 64'd30);
    check("b2b_second_hi", 64'(hi_out), 64'd0);

    // MFHI issued 5 cycles after a MULT start
    valid = 1'b1; hi_en = 1'b1; lo_en = 1'b1; funct = 6'h18;
    rs_val = 32'hFFFF_FFFD; rt_val = 32'd5;
    tick();
    hi_en = 1'b0; lo_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    alu_lo_hi = 2'b01;
    #1;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1 || mf_result !== 32'h0) bad++;
      tick();
      n++;
    end
    check("mfhi_stall_old_value", 64'(bad), 64'd0);
    check("mfhi_new_value", 64'(mf_result), 64'hFFFF_FFFF);
    check("mfhi_no_stall", 64'(stall), 64'd0);
    alu_lo_hi = 2'b10;
    #1;
    check("mflo_value", 64'(mf_result), 64'hFFFF_FFF1);
    alu_lo_hi = 2'b00;
    valid = 1'b0;

    // Load HI=0x1234, then kill at counter 10
    run_mult(6'h19, 32'h1234_0000, 32'h0001_0000, n);
    check("setup_hi_1234", 64'(hi_out), 64'h1234);
    valid = 1'b1; hi_en = 1'b1; lo_en = 1'b1; funct = 6'h19;
    rs_val = 32'd7; rt_val = 32'hFFFF_FFFF;
    tick();
    valid = 1'b0; hi_en = 1'b0; lo_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) tick();
    check("kill_hi_kept", 64'(hi_out), 64'h1234);
    check("kill_lo_kept", 64'(lo_out), 64'h0);

    // Reset at counter 10
    valid = 1'b1; hi_en = 1'b1; lo_en = 1'b1;
    rs_val = 32'd3; rt_val = 32'hFFFF_FFFF;
    tick();
    valid = 1'b0; hi_en = 1'b0; lo_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi_out), 64'h0);
    check("rst_mid_lo", 64'(lo_out), 64'h0);

    // Kill alongside a request in IDLE blocks acceptance
    valid = 1'b1; hi_en = 1'b1; lo_en = 1'b1; kill = 1'b1;
    tick();
    valid = 1'b0; hi_en = 1'b0; lo_en = 1'b0; kill = 1'b0;
    check("idle_kill_blocks", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
